// File: rtl/ifu_prefetch_pkg.sv
// Shared fetch-stage constants: bus widths, reset PC and the PC step.
package ifu_prefetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;
    localparam int unsigned PC_STEP     = 4;

    localparam logic [INST_ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INST_W-1:0]      ZERO_WORD    = 32'h0000_0000;

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Synchronous FIFO with flush; head entry is read straight from storage.
module ifu_prefetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [WIDTH-1:0]             i_wdata,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Full/empty guards keep the queue consistent even if a caller misbehaves.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch stage: owns the PC, drives inst_rom and queues {pc, inst} for decode.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = INST_ADDR_W,
    parameter int unsigned       DATA_W   = INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         rom_ce_o,
    output logic [ADDR_W-1:0]            rom_addr_o,
    input  logic [DATA_W-1:0]            rom_data_i,
    input  logic                         redirect_i,
    input  logic [ADDR_W-1:0]            redirect_pc_i,
    output logic                         if_valid_o,
    output logic [ADDR_W-1:0]            if_pc_o,
    output logic [DATA_W-1:0]            if_inst_o,
    input  logic                         id_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count_o
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic               r_run;
    logic [ADDR_W-1:0]  r_pc;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;

    // A redirect kills both the fetch and the pop of its own cycle.
    assign rom_ce_o   = r_run & ~w_full & ~redirect_i;
    assign rom_addr_o = r_pc;
    assign w_push     = rom_ce_o;
    assign w_pop      = ~w_empty & id_ready_i & ~redirect_i;

    assign if_valid_o = ~w_empty;
    assign if_pc_o    = w_head[ENTRY_W-1:DATA_W];
    assign if_inst_o  = w_head[DATA_W-1:0];

    // run gates fetch off for the first cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
            r_pc  <= RESET_PC;
        end else begin
            r_run <= 1'b1;
            if (redirect_i) begin
                r_pc <= redirect_pc_i & ~ADDR_W'(3);
            end else if (w_push) begin
                r_pc <= r_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    ifu_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .i_wdata ({r_pc, rom_data_i}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count_o)
    );

endmodule
